// File: rtl/lcd_cmd_sequencer.sv
// HD44780 command sequencer: power-up init ROM, then drains a {rs,byte} FIFO; LCD_LINE_WRAP_EN adds auto line wrap.
// Latency: FIFO write while idle -> lcd_en rises 4 cycles later; each byte then owns setup+pulse+hold time.
// Backpressure: wr_ready drops only when the FIFO is full; requesters never wait on LCD timing.

module lcd_seq_fifo #(
    parameter int unsigned W  = 9,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    output logic          ready,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [AW:0]   level
);
    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned LW    = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign ready   = (level != LW'(DEPTH));
    assign do_push = push && ready;
    assign do_pop  = pop && (level != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

module lcd_cmd_sequencer #(
    parameter int unsigned EN_CYCLES    = 25,
    parameter int unsigned HOLD_CYCLES  = 2500,
    parameter int unsigned LONG_CYCLES  = 82000,
    parameter int unsigned PWRUP_CYCLES = 750000,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic               wr_rs,
    input  logic [7:0]         wr_data,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               init_done,
    output logic               busy,
    output logic               lcd_rs,
    output logic               lcd_rw,
    output logic               lcd_en,
    output logic [7:0]         lcd_db
);
    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_LOAD,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_IDLE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] timer;
    logic [31:0] hold_len;
    logic        timer_done;
    logic [3:0]  init_idx;
    logic        init_complete;
    logic        long_hold;

    logic [8:0]  fifo_head;
    logic        fifo_empty;

    logic        take_rom;
    logic        take_fifo;
    logic        sel_rs;
    logic [7:0]  sel_db;
    logic        sel_long;

    function automatic logic [7:0] rom_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: rom_byte = 8'h30;
            3'd3:             rom_byte = 8'h38;
            3'd4:             rom_byte = 8'h08;
            3'd5:             rom_byte = 8'h01;
            3'd6:             rom_byte = 8'h06;
            default:          rom_byte = 8'h0C;
        endcase
    endfunction

    // Wake-up bytes and clear need the long settle time.
    function automatic logic rom_long(input logic [2:0] idx);
        rom_long = (idx < 3'd3) || (idx == 3'd5);
    endfunction

    function automatic logic cmd_long(input logic rs, input logic [7:0] data);
        cmd_long = !rs && (data inside {8'h01, 8'h02, 8'h03});
    endfunction

    lcd_seq_fifo #(
        .W  (9),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_valid),
        .push_data ({wr_rs, wr_data}),
        .ready     (wr_ready),
        .pop       (take_fifo),
        .head      (fifo_head),
        .level     (fifo_level)
    );

    assign fifo_empty    = (fifo_level == '0);
    assign init_complete = init_idx[3];
    assign busy          = (state != ST_IDLE) || !fifo_empty;
    assign lcd_rw        = 1'b0;
    assign hold_len      = long_hold ? LONG_CYCLES : HOLD_CYCLES;

`ifdef LCD_LINE_WRAP_EN
    logic       cur_line;
    logic [3:0] cur_col;
    logic       wrap_pend;
    logic       take_inj;
`endif

    always_comb begin
        case (state)
            ST_PWRUP: timer_done = (timer == PWRUP_CYCLES - 1);
            ST_PULSE: timer_done = (timer == EN_CYCLES - 1);
            ST_HOLD:  timer_done = (timer == hold_len - 1);
            default:  timer_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_PWRUP;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        take_rom   = 1'b0;
        take_fifo  = 1'b0;
        sel_rs     = 1'b0;
        sel_db     = 8'h00;
        sel_long   = 1'b0;
`ifdef LCD_LINE_WRAP_EN
        take_inj   = 1'b0;
`endif
        case (state)
            ST_PWRUP: begin
                if (timer_done) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_SETUP;
                if (!init_complete) begin
                    take_rom = 1'b1;
                    sel_db   = rom_byte(init_idx[2:0]);
                    sel_long = rom_long(init_idx[2:0]);
                end
`ifdef LCD_LINE_WRAP_EN
                else if (wrap_pend) begin
                    take_inj = 1'b1;
                    sel_db   = cur_line ? 8'h80 : 8'hC0;
                end
`endif
                else if (!fifo_empty) begin
                    take_fifo = 1'b1;
                    sel_rs    = fifo_head[8];
                    sel_db    = fifo_head[7:0];
                    sel_long  = cmd_long(fifo_head[8], fifo_head[7:0]);
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SETUP: state_next = ST_PULSE;
            ST_PULSE: begin
                if (timer_done) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (timer_done) begin
                    state_next = ST_LOAD;
                end
            end
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_next = ST_LOAD;
                end
            end
            default: state_next = ST_PWRUP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer     <= '0;
            init_idx  <= '0;
            init_done <= 1'b0;
            long_hold <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_db    <= 8'h00;
            lcd_en    <= 1'b0;
        end else begin
            timer  <= ((state_next != state) || (state == ST_IDLE)) ? '0 : timer + 32'd1;
            lcd_en <= (state_next == ST_PULSE);
            // Bus only moves when a new entry is selected; it idles on the last byte.
            if ((state == ST_LOAD) && (state_next == ST_SETUP)) begin
                lcd_rs    <= sel_rs;
                lcd_db    <= sel_db;
                long_hold <= sel_long;
            end
            if (take_rom) begin
                init_idx <= init_idx + 4'd1;
            end
            if ((state == ST_HOLD) && timer_done && init_complete) begin
                init_done <= 1'b1;
            end
        end
    end

`ifdef LCD_LINE_WRAP_EN
    // Cursor model mirrors what the controller's address counter does for queued traffic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_line  <= 1'b0;
            cur_col   <= 4'd0;
            wrap_pend <= 1'b0;
        end else if (take_inj) begin
            cur_line  <= ~cur_line;
            cur_col   <= 4'd0;
            wrap_pend <= 1'b0;
        end else if (take_fifo) begin
            if (fifo_head[8]) begin
                if (cur_col == 4'd15) begin
                    wrap_pend <= 1'b1;
                end
                cur_col <= cur_col + 4'd1;
            end else if (cmd_long(1'b0, fifo_head[7:0])) begin
                cur_line <= 1'b0;
                cur_col  <= 4'd0;
            end else if (fifo_head[7]) begin
                cur_line <= fifo_head[6];
                cur_col  <= fifo_head[3:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Randomized scoreboard bench for lcd_cmd_sequencer: expected LCD bytes and timing come from a queue-based model.
// Monitor pops one expectation per lcd_en pulse and checks content, pulse width, gaps and status flags.
module tb_lcd_cmd_sequencer;
    localparam int EN    = 2;
    localparam int HOLD  = 5;
    localparam int LONG  = 20;
    localparam int PWRUP = 50;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic          wr_rs = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic [AW:0]   fifo_level;
    logic          init_done;
    logic          busy;
    logic          lcd_rs;
    logic          lcd_rw;
    logic          lcd_en;
    logic [7:0]    lcd_db;

    always #5 clk = ~clk;

    lcd_cmd_sequencer #(
        .EN_CYCLES    (EN),
        .HOLD_CYCLES  (HOLD),
        .LONG_CYCLES  (LONG),
        .PWRUP_CYCLES (PWRUP),
        .FIFO_AW      (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_rs      (wr_rs),
        .wr_data    (wr_data),
        .fifo_level (fifo_level),
        .init_done  (init_done),
        .busy       (busy),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_en     (lcd_en),
        .lcd_db     (lcd_db)
    );

    typedef struct {
        logic       rs;
        logic [7:0] db;
        int         hold;
        int         push_cyc;
        bit         idle_push;
        bit         rom;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_push_cyc = 0;
    int   m_line = 0;
    int   m_col = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit long_cmd(input logic rs, input logic [7:0] d);
        return !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    endfunction

    task automatic model_reset();
        logic [7:0] rom [8];
        exp_t e;
        rom = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
        expq.delete();
        for (int i = 0; i < 8; i++) begin
            e = '{default: 0};
            e.rs = 1'b0;
            e.db = rom[i];
            e.hold = (i < 3 || i == 5) ? LONG : HOLD;
            e.rom = 1'b1;
            expq.push_back(e);
        end
        m_line = 0;
        m_col = 0;
        last_push_cyc = 0;
    endtask

    task automatic model_push(input logic rs, input logic [7:0] d, input bit idle);
        exp_t e;
        e = '{default: 0};
        e.rs = rs;
        e.db = d;
        e.hold = long_cmd(rs, d) ? LONG : HOLD;
        e.push_cyc = cyc + 1;
        e.idle_push = idle;
        expq.push_back(e);
`ifdef LCD_LINE_WRAP_EN
        if (rs) begin
            if (m_col == 15) begin
                e.rs = 1'b0;
                e.db = (m_line == 1) ? 8'h80 : 8'hC0;
                e.hold = HOLD;
                e.idle_push = 1'b0;
                expq.push_back(e);
                m_line = 1 - m_line;
                m_col = 0;
            end else begin
                m_col++;
            end
        end else if (long_cmd(rs, d)) begin
            m_line = 0;
            m_col = 0;
        end else if (d[7]) begin
            m_line = int'(d[6]);
            m_col = int'(d[3:0]);
        end
`endif
    endtask

    // Caller is positioned at a negedge; returns at the negedge after the handshake.
    task automatic send(input logic rs, input logic [7:0] d);
        int n = 0;
        while (!wr_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("wr_ready_wait", wr_ready, 1);
        if (wr_ready) begin
            wr_valid = 1'b1;
            wr_rs = rs;
            wr_data = d;
            model_push(rs, d, !busy);
            last_push_cyc = cyc + 1;
            @(negedge clk);
            wr_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while ((busy || expq.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 0);
    endtask

    initial begin : monitor
        bit   prev_en;
        bit   first;
        int   width;
        int   fall;
        int   prev_hold;
        int   rom_seen;
        int   init_cyc;
        int   idle_chk;
        exp_t cur;
        prev_en = 0; first = 1; width = 0; fall = 0; prev_hold = 0;
        rom_seen = 0; init_cyc = -1; idle_chk = -1;
        cur = '{default: 0};
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (reset) begin
                cyc = 0; prev_en = 0; first = 1; width = 0;
                rom_seen = 0; init_cyc = -1; idle_chk = -1;
                continue;
            end
            check("lcd_rw", lcd_rw, 0);
            check("init_done", init_done, (init_cyc >= 0 && cyc >= init_cyc) ? 1 : 0);
            if (idle_chk >= 0 && expq.size() == 0 && last_push_cyc <= fall) begin
                if (cyc == idle_chk - 1) check("busy_before_idle", busy, 1);
                if (cyc == idle_chk) begin
                    check("busy_idle", busy, 0);
                    idle_chk = -1;
                end
            end
            if (lcd_en && !prev_en) begin
                idle_chk = -1;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got rs=%b db=0x%0h, expected no pulse", lcd_rs, lcd_db);
                    cur = '{default: 0};
                    cur.hold = HOLD;
                end else begin
                    cur = expq.pop_front();
                    check("pulse_rs", lcd_rs, cur.rs);
                    check("pulse_db", lcd_db, cur.db);
                    if (first)
                        check("pwrup_first_rise", cyc, PWRUP + 2);
                    else if (cur.idle_push)
                        check("idle_latency", cyc, cur.push_cyc + 3);
                    else if (cur.push_cyc <= fall)
                        check("hold_gap", cyc - fall, prev_hold + 2);
                    else begin
                        checks++;
                        if (cyc - fall < prev_hold + 2) begin
                            errors++;
                            $display("FAIL min_gap: got %0d, expected at least %0d", cyc - fall, prev_hold + 2);
                        end
                    end
                end
                first = 0;
                width = 1;
            end else if (lcd_en) begin
                width++;
            end else if (prev_en) begin
                check("pulse_width", width, EN);
                check("hold_db", lcd_db, cur.db);
                fall = cyc;
                prev_hold = cur.hold;
                if (cur.rom) begin
                    rom_seen++;
                    if (rom_seen == 8) init_cyc = cyc + cur.hold;
                end
                if (expq.size() == 0 && last_push_cyc <= cyc) idle_chk = cyc + cur.hold + 1;
            end
            prev_en = lcd_en;
        end
    end

    initial begin : driver
        logic [7:0] d;
        logic       rs;
        int         n;
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_lcd_en", lcd_en, 0);
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_lcd_db", lcd_db, 0);
        check("rst_lcd_rw", lcd_rw, 0);
        check("rst_init_done", init_done, 0);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_busy", busy, 1);
        reset = 1'b0;

        // Fill the FIFO during power-up; the fifth write must be refused.
        for (int i = 0; i < 4; i++) send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        check("full_wr_ready", wr_ready, 0);
        check("full_level", fifo_level, 4);
        wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'hEE;
        @(negedge clk);
        wr_valid = 1'b0;
        check("full_level_after_push", fifo_level, 4);
        wait_idle("drain_init");
        check("init_done_after_init", init_done, 1);

        send(1'b1, 8'h41);
        wait_idle("drain_41");
        send(1'b0, 8'h01);
        send(1'b1, 8'h42);
        wait_idle("drain_clear");

        send(1'b0, 8'h80);
        for (int i = 0; i < 17; i++) send(1'b1, 8'(8'h61 + i));
        wait_idle("drain_wrap");

        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            rs = 1'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(1, 3));
            send(rs, d);
        end
        wait_idle("drain_random");

        // Reset in the middle of a pulse with a partly full FIFO.
        for (int i = 0; i < 4; i++) send(1'b1, 8'(8'h50 + i));
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(lcd_en && fifo_level == 3) && n < 50);
        check("pre_reset_en", lcd_en, 1);
        check("pre_reset_level", fifo_level, 3);
        reset = 1'b1;
        #1;
        check("mid_reset_en", lcd_en, 0);
        check("mid_reset_level", fifo_level, 0);
        check("mid_reset_init_done", init_done, 0);
        check("mid_reset_busy", busy, 1);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_idle("drain_replay");

        send(1'b1, 8'h5A);
        send(1'b0, 8'h02);
        wait_idle("drain_final");
        check("queue_empty", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_cmd_sequencer.md
Name: lcd_cmd_sequencer

Overview:
Sequencer and buffer in front of the 8-bit HD44780-style character LCD on the Nios board. After reset it runs the LCD power-up init sequence autonomously. It then drains a FIFO of {rs, byte} entries written by upstream logic (Nios custom instruction or HW status writer). For each entry it generates setup, enable-pulse and post-byte hold timing, so requesters never wait on LCD timing directly.

Parameters:
EN_CYCLES, 25, lcd_en high width in clk cycles (>=1)
HOLD_CYCLES, 2500, wait after en falls for normal commands/data (~50 us @ 50 MHz)
LONG_CYCLES, 82000, wait after en falls for clear (0x01), home (0x02/0x03) and init wake-up bytes (~1.64 ms)
PWRUP_CYCLES, 750000, wait after reset before first init byte (~15 ms)
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
wr_valid  in  1  upstream write request
wr_ready  out  1  FIFO can accept; transfer when wr_valid && wr_ready on posedge clk
wr_rs  in  1  0 = instruction, 1 = data
wr_data  in  8  byte to send
fifo_level  out  FIFO_AW+1  entries currently queued
init_done  out  1  high once init ROM fully sent; stays high until reset
busy  out  1  high whenever state != IDLE or FIFO non-empty
lcd_rs  out  1  LCD register select
lcd_rw  out  1  tied 0 (write only)
lcd_en  out  1  LCD enable strobe
lcd_db  out  8  LCD data bus

Behaviour:
- Reset (async): state=PWRUP, timer=0, FIFO pointers=0, init index=0. Outputs: lcd_rs=0, lcd_en=0, lcd_db=0x00, lcd_rw=0, init_done=0, fifo_level=0, wr_ready=1, busy=1.
- Init ROM, 8 instruction bytes (rs=0) in order: 0x30, 0x30, 0x30, 0x38, 0x08, 0x01, 0x06, 0x0C. The first three bytes and 0x01 use LONG_CYCLES hold; the rest use HOLD_CYCLES.
- States:
  - PWRUP: count PWRUP_CYCLES, then LOAD.
  - LOAD: if init incomplete, take next ROM byte. Else, if FIFO non-empty, pop head. Else go to IDLE. Drive lcd_rs/lcd_db from the selected entry; go to SETUP.
  - SETUP: exactly 1 cycle with rs/db stable and en=0; then PULSE.
  - PULSE: en=1 for EN_CYCLES cycles, then en=0 and go to HOLD.
  - HOLD: wait HOLD_CYCLES or LONG_CYCLES, then LOAD. init_done is set on exit from HOLD of the 8th ROM byte.
  - IDLE: go to LOAD in the cycle after the FIFO becomes non-empty.
- lcd_rs/lcd_db hold their last value through HOLD and IDLE; they change only in LOAD.
- Long-hold selection for FIFO entries: rs=0 and data in {0x01, 0x02, 0x03}.
- Byte latency: FIFO write at cycle t with the sequencer idle -> LOAD at t+2 -> en rises at t+4.
- FIFO:
  - wr_ready = (fifo_level != 2**FIFO_AW).
  - Writes are accepted during PWRUP and init; they are held until init_done.
  - Push and pop in the same cycle leave fifo_level unchanged. Push when full is impossible (ready=0) and has no effect.
  - Pointers wrap modulo 2**FIFO_AW; level is computed at FIFO_AW+1 bits.
- Reset mid-pulse or mid-init: en drops immediately, FIFO is emptied, and the init sequence restarts from PWRUP.

Optional Feature:
LCD_LINE_WRAP_EN
- Defined: the sequencer tracks cursor line (0/1) and column (0..15).
  - Each rs=1 byte increments the column.
  - After the HOLD of the column-15 data byte, an auto command is injected before the next FIFO pop: 0xC0 if on line 0, 0x80 if on line 1. It uses HOLD_CYCLES and toggles the line. Column resets to 0.
  - rs=0 0x01/0x02/0x03 sets line=0, col=0.
  - rs=0 set-DDRAM (bit7=1) sets line=data[6], col=data[3:0].
  - Injected commands do not count in fifo_level.
- Undefined: no tracking and no injection; bytes are sent exactly as queued.

Test Plan:
- Sim parameters: EN=2, HOLD=5, LONG=20, PWRUP=50, AW=2.
- Reset release -> 50 cycles en=0, then 8 en pulses each 2 cycles wide with db=0x30,0x30,0x30,0x38,0x08,0x01,0x06,0x0C and rs=0; gaps are LONG/HOLD per rule; init_done rises after the last hold; busy falls.
- Write 5 bytes during PWRUP -> 4 accepted, wr_ready=0 on 5th with fifo_level=4; after init the 4 bytes go out in order with rs/db matching.
- After init, write {rs=1, 0x41} -> en rises 4 cycles after the handshake cycle; db=0x41, rs=1; 5-cycle hold; busy drops after.
- Queue {rs=0, 0x01} then {rs=1, 0x42} -> 20-cycle hold after 0x01, 5-cycle hold after 0x42.
- Assert reset while lcd_en=1 with fifo_level=3 -> en=0 immediately, fifo_level=0, init_done=0, init ROM replays from 0x30.
- With LCD_LINE_WRAP_EN: send 0x80 then 17 data bytes -> 0xC0 (rs=0) appears between the 16th and 17th data bytes. Without the macro: no 0xC0 appears.
